// File: rtl/alu_types.sv
// Shared types for the RV32I ALU: operation encodings and a printable name helper.
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1111
    } alu_control_t;

    function automatic string alu_control_name(alu_control_t op);
        case (op)
            ALU_AND:  return "AND";
            ALU_OR:   return "OR";
            ALU_XOR:  return "XOR";
            ALU_SLL:  return "SLL";
            ALU_SRL:  return "SRL";
            ALU_SRA:  return "SRA";
            ALU_ADD:  return "ADD";
            ALU_SUB:  return "SUB";
            ALU_SLT:  return "SLT";
            ALU_SLTU: return "SLTU";
            default:  return "UNDEF";
        endcase
    endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit adder with carry in/out, shared by ADD, SUB and the set-less-than compares.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};

endmodule

// File: rtl/alu32.sv
// Combinational RV32I ALU with overflow/zero/equal flags and a registered sticky overflow.
module alu32
    import alu_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  alu_control_t op,
    output logic [31:0]  out,
    output logic         overflow,
    output logic         outputs_zero,
    output logic         inputs_equal,
    output logic         overflow_sticky
);

    logic        is_add;
    logic [31:0] adder_b;
    logic [31:0] sum;
    logic        c_out;
    logic        add_ovf;
    logic        sub_ovf;

    // Everything except ADD runs the adder as a - b = a + ~b + 1.
    assign is_add  = (op == ALU_ADD);
    assign adder_b = is_add ? b : ~b;

    adder_32 u_adder (
        .a     (a),
        .b     (adder_b),
        .c_in  (~is_add),
        .sum   (sum),
        .c_out (c_out)
    );

    assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    assign sub_ovf = (a[31] != b[31]) && (sum[31] != a[31]);

    logic        sr_fill;
    logic [31:0] sl0, sl1, sl2, sl3, sl4;
    logic [31:0] sr0, sr1, sr2, sr3, sr4;

    assign sl0 = b[0] ? {a[30:0],   1'b0}  : a;
    assign sl1 = b[1] ? {sl0[29:0], 2'b0}  : sl0;
    assign sl2 = b[2] ? {sl1[27:0], 4'b0}  : sl1;
    assign sl3 = b[3] ? {sl2[23:0], 8'b0}  : sl2;
    assign sl4 = b[4] ? {sl3[15:0], 16'b0} : sl3;

    // One right shifter serves SRL and SRA; only the fill bit differs.
    assign sr_fill = (op == ALU_SRA) & a[31];
    assign sr0 = b[0] ? {sr_fill,        a[31:1]}    : a;
    assign sr1 = b[1] ? {{2{sr_fill}},   sr0[31:2]}  : sr0;
    assign sr2 = b[2] ? {{4{sr_fill}},   sr1[31:4]}  : sr1;
    assign sr3 = b[3] ? {{8{sr_fill}},   sr2[31:8]}  : sr2;
    assign sr4 = b[4] ? {{16{sr_fill}},  sr3[31:16]} : sr3;

    always_comb begin
        out      = 32'b0;
        overflow = 1'b0;
        case (op)
            ALU_AND:  out = a & b;
            ALU_OR:   out = a | b;
            ALU_XOR:  out = a ^ b;
            ALU_SLL:  out = sl4;
            ALU_SRL:  out = sr4;
            ALU_SRA:  out = sr4;
            ALU_ADD: begin
                out      = sum;
                overflow = add_ovf;
            end
            ALU_SUB: begin
                out      = sum;
                overflow = sub_ovf;
            end
            // Sign of the difference is wrong exactly when the subtraction overflowed.
            ALU_SLT:  out = {31'b0, sum[31] ^ sub_ovf};
            ALU_SLTU: out = {31'b0, ~c_out};
            default: begin
                out      = 32'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign outputs_zero = (out == 32'b0);
    assign inputs_equal = (a == b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_sticky <= 1'b0;
        end else begin
            overflow_sticky <= overflow_sticky | overflow;
        end
    end

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: directed spec vectors, full op sweep and random pairs.
`timescale 1ns/1ps
module tb_alu32;
    import alu_types::*;

    typedef struct {
        alu_control_t op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  out;
        logic         ovf;
        logic         zero;
        logic         eq;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  a;
    logic [31:0]  b;
    alu_control_t op;
    logic [31:0]  out;
    logic         overflow;
    logic         outputs_zero;
    logic         inputs_equal;
    logic         overflow_sticky;

    exp_t sb_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_sticky = 1'b0;

    alu32 dut (
        .clk             (clk),
        .rst             (rst),
        .a               (a),
        .b               (b),
        .op              (op),
        .out             (out),
        .overflow        (overflow),
        .outputs_zero    (outputs_zero),
        .inputs_equal    (inputs_equal),
        .overflow_sticky (overflow_sticky)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on integers, overflow = true result does not fit in 32 bits.
    function automatic exp_t alu_behavioural(alu_control_t o, logic [31:0] av, logic [31:0] bv);
        exp_t   e;
        longint sa, sb, r, tr;
        sa    = $signed(av);
        sb    = $signed(bv);
        e.op  = o;
        e.a   = av;
        e.b   = bv;
        e.out = 32'b0;
        e.ovf = 1'b0;
        case (o)
            ALU_AND:  e.out = av & bv;
            ALU_OR:   e.out = av | bv;
            ALU_XOR:  e.out = av ^ bv;
            ALU_SLL:  e.out = av << bv[4:0];
            ALU_SRL:  e.out = av >> bv[4:0];
            ALU_SRA:  e.out = $unsigned($signed(av) >>> bv[4:0]);
            ALU_ADD: begin
                r     = sa + sb;
                e.out = r[31:0];
                tr    = $signed(e.out);
                e.ovf = (r != tr);
            end
            ALU_SUB: begin
                r     = sa - sb;
                e.out = r[31:0];
                tr    = $signed(e.out);
                e.ovf = (r != tr);
            end
            ALU_SLT:  e.out = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: e.out = (av < bv) ? 32'd1 : 32'd0;
            default:  e.out = 32'b0;
        endcase
        e.zero = (e.out == 32'b0);
        e.eq   = (av == bv);
        return e;
    endfunction

    function automatic exp_t mk(alu_control_t o, logic [31:0] av, logic [31:0] bv,
                                logic [31:0] ov, logic of, logic z, logic q);
        exp_t e;
        e.op = o; e.a = av; e.b = bv; e.out = ov; e.ovf = of; e.zero = z; e.eq = q;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(input exp_t e);
        @(negedge clk);
        op = e.op;
        a  = e.a;
        b  = e.b;
        sb_q.push_back(e);
        #1 -> sample_ev;
    endtask

    task automatic drive_model(input alu_control_t o, input logic [31:0] av, input logic [31:0] bv);
        drive(alu_behavioural(o, av, bv));
    endtask

    always @(posedge clk or posedge rst) begin
        exp_t t;
        if (rst) begin
            m_sticky <= 1'b0;
        end else begin
            t = alu_behavioural(op, a, b);
            m_sticky <= m_sticky | t.ovf;
        end
    end

    // Monitor: pops one expectation per sample strobe and compares every output.
    initial begin
        exp_t  e;
        string tag;
        forever begin
            @(sample_ev);
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e   = sb_q.pop_front();
                tag = $sformatf("%s a=%h b=%h", alu_control_name(e.op), e.a, e.b);
                check({tag, " out"},          out,                    e.out);
                check({tag, " overflow"},     {31'b0, overflow},      {31'b0, e.ovf});
                check({tag, " outputs_zero"}, {31'b0, outputs_zero},  {31'b0, e.zero});
                check({tag, " inputs_equal"}, {31'b0, inputs_equal},  {31'b0, e.eq});
                check({tag, " sticky"},       {31'b0, overflow_sticky}, {31'b0, m_sticky});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0]  vals [4];
        alu_control_t o;
        logic [31:0]  ra, rb;

        vals[0] = 32'h0000_0000;
        vals[1] = 32'h0000_0001;
        vals[2] = 32'h7FFF_FFFF;
        vals[3] = 32'hFFFF_FFFF;

        rst = 1'b1;
        op  = ALU_AND;
        a   = 32'b0;
        b   = 32'b0;
        #2 check("reset_sticky", {31'b0, overflow_sticky}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(mk(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        #1 check("sticky_after_add_ovf", {31'b0, overflow_sticky}, 32'd1);

        drive(mk(ALU_SUB,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b1));
        drive(mk(ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0));
        drive(mk(ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0));
        drive(mk(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0));
        drive(mk(ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0));
        drive(mk(ALU_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
        drive(mk(ALU_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0));
        drive(mk(ALU_SLL,  32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 1'b0, 1'b0, 1'b0));
        drive(mk(alu_control_t'(4'b0000), 32'h0000_0005, 32'h0000_0009,
                 32'h0000_0000, 1'b0, 1'b1, 1'b0));

        @(negedge clk);
        #1 check("sticky_held", {31'b0, overflow_sticky}, 32'd1);
        #1 rst = 1'b1;
        #1 check("sticky_async_clear", {31'b0, overflow_sticky}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int code = 0; code < 16; code++) begin
            o = alu_control_t'(4'(code));
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    drive_model(o, vals[i], vals[j]);
                end
            end
            for (int k = 0; k < 8; k++) begin
                ra = $urandom;
                if (o == ALU_SLL || o == ALU_SRL || o == ALU_SRA) begin
                    rb = $urandom_range(0, 31);
                end else begin
                    rb = $urandom;
                end
                drive_model(o, ra, rb);
            end
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
